// File: rtl/mult_pkg.sv
// Shared constants and bit-level helpers for the pipelined Dadda multiplier.
// The Dadda height sequence drives how many reduction layers a given WIDTH needs.
package mult_pkg;

  localparam int WIDTH_MIN   = 4;
  localparam int WIDTH_MAX   = 32;
  localparam int DADDA_STEPS = 8;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // d_0 = 2, d_(j+1) = floor(1.5 * d_j): 2, 3, 4, 6, 9, 13, 19, 28
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int i = 0; i < j; i++) begin
      d = (d * 3) / 2;
    end
    return d;
  endfunction

  // {carry, sum}
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

endpackage

// File: rtl/multiplier_nbits_cla_adder.sv
// W-bit carry-lookahead adder built as a Kogge-Stone prefix over generate/propagate.
// Purely combinational; used for the final two-row add of the multiplier.
module cla_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W-1:0] grp_g;
  logic [W-1:0] grp_p;
  logic [W-1:0] carry;

  always_comb begin
    gen   = a & b;
    prop  = a ^ b;
    grp_g = gen;
    grp_p = prop;
    // Walking downwards lets each prefix level update in place.
    for (int s = 1; s < W; s = s * 2) begin
      for (int i = W - 1; i >= s; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-s]);
        grp_p[i] = grp_p[i] & grp_p[i-s];
      end
    end
    carry = {grp_g[W-2:0], 1'b0};
    sum   = prop ^ carry;
    cout  = grp_g[W-1];
  end

endmodule

// File: rtl/multiplier_nbits_pipelined.sv
// WIDTH x WIDTH multiplier, unsigned or Baugh-Wooley signed per transaction,
// Dadda reduction plus CLA final add, PIPE_STAGES-deep valid/ready pipeline.
module multiplier_nbits_pipelined
  import mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 3,
  parameter int SIGNED_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int COL_H  = WIDTH + 1;

  typedef struct packed {
    logic             valid;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  typedef struct packed {
    logic              valid;
    logic              is_signed;
    logic [PROD_W-1:0] row0;
    logic [PROD_W-1:0] row1;
  } stage_t;

  logic   adv;
  op_t    op_in;
  op_t    op_cur;
  stage_t rows_comb;
  stage_t rows_cur;

  logic [COL_H-1:0] cur_bits [PROD_W];
  logic [COL_H-1:0] nxt_bits [PROD_W];
  int               cur_h    [PROD_W];
  int               nxt_h    [PROD_W];
  int               k;
  int               rem;
  int               tot;
  int               d;
  logic             pp_bit;
  logic [1:0]       add_r;

  logic [PROD_W-2:0] sum_lo;
  logic              sum_cout;
  logic [PROD_W-1:0] sum_full;

  logic              out_valid_q, out_valid_d;
  logic [PROD_W-1:0] product_q, product_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    op_in.valid     = in_valid;
    op_in.is_signed = (SIGNED_EN != 0) && is_signed;
    op_in.a         = a;
    op_in.b         = b;
  end

  // Partial products are one gate level, so the first register holds the operands they need.
  if (PIPE_STAGES >= 3) begin : g_pp_reg
    op_t op_q, op_d;
    always_comb op_d = adv ? op_in : op_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) op_q <= '0;
      else        op_q <= op_d;
    end
    assign op_cur = op_q;
  end else begin : g_pp_comb
    assign op_cur = op_in;
  end

  // Column heights depend only on WIDTH, so every index below folds to a constant.
  always_comb begin
    cur_bits = '{default: '0};
    nxt_bits = '{default: '0};
    cur_h    = '{default: 0};
    nxt_h    = '{default: 0};
    k        = 0;
    rem      = 0;
    tot      = 0;
    d        = 0;
    pp_bit   = 1'b0;
    add_r    = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_bit = op_cur.a[j] & op_cur.b[i];
        if (op_cur.is_signed && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp_bit = ~pp_bit;
        cur_bits[i+j][cur_h[i+j]] = pp_bit;
        cur_h[i+j] += 1;
      end
    end
    // Baugh-Wooley +2^WIDTH; the +2^(2W-1) term is folded into the final MSB instead.
    cur_bits[WIDTH][cur_h[WIDTH]] = op_cur.is_signed;
    cur_h[WIDTH] += 1;

    for (int s = DADDA_STEPS - 1; s >= 0; s--) begin
      d = dadda_height(s);
      if (d < WIDTH) begin
        nxt_bits = '{default: '0};
        nxt_h    = '{default: 0};
        for (int c = 0; c < PROD_W; c++) begin
          k = 0;
          for (int it = 0; it < COL_H; it++) begin
            rem = cur_h[c] - k;
            tot = rem + nxt_h[c];
            if (rem >= 2 && tot > d) begin
              if (rem >= 3 && tot > d + 1) begin
                add_r = full_add(cur_bits[c][k], cur_bits[c][k+1], cur_bits[c][k+2]);
                k += 3;
              end else begin
                add_r = half_add(cur_bits[c][k], cur_bits[c][k+1]);
                k += 2;
              end
              nxt_bits[c][nxt_h[c]] = add_r[0];
              nxt_h[c] += 1;
              if (c + 1 < PROD_W) begin
                nxt_bits[c+1][nxt_h[c+1]] = add_r[1];
                nxt_h[c+1] += 1;
              end
            end else if (rem >= 1) begin
              nxt_bits[c][nxt_h[c]] = cur_bits[c][k];
              nxt_h[c] += 1;
              k += 1;
            end
          end
        end
        cur_bits = nxt_bits;
        cur_h    = nxt_h;
      end
    end

    rows_comb.valid     = op_cur.valid;
    rows_comb.is_signed = op_cur.is_signed;
    rows_comb.row0      = '0;
    rows_comb.row1      = '0;
    for (int c = 0; c < PROD_W; c++) begin
      rows_comb.row0[c] = cur_bits[c][0];
      rows_comb.row1[c] = cur_bits[c][1];
    end
  end

  if (PIPE_STAGES >= 2) begin : g_rows_reg
    stage_t rows_q, rows_d;
    always_comb rows_d = adv ? rows_comb : rows_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rows_q <= '0;
      else        rows_q <= rows_d;
    end
    assign rows_cur = rows_q;
  end else begin : g_rows_comb
    assign rows_cur = rows_comb;
  end

  cla_adder #(.W(PROD_W - 1)) u_cla (
    .a    (rows_cur.row0[PROD_W-2:0]),
    .b    (rows_cur.row1[PROD_W-2:0]),
    .sum  (sum_lo),
    .cout (sum_cout)
  );

  assign sum_full = {rows_cur.row0[PROD_W-1] ^ rows_cur.row1[PROD_W-1] ^ sum_cout ^ rows_cur.is_signed,
                     sum_lo};

  always_comb begin
    out_valid_d = out_valid_q;
    product_d   = product_q;
    if (adv) begin
      out_valid_d = rows_cur.valid;
      if (rows_cur.valid) product_d = sum_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
